// File: rtl/pipe_reg_chain_pkg.sv
// pipe_reg_chain_pkg
//   Shared constants and helpers for the pipe_reg_chain slice.
//   - MIN_DEPTH : smallest legal number of register stages.
//   - occ_width : bit width needed to count 0..depth valid stages.
package pipe_reg_chain_pkg;

  localparam int MIN_DEPTH = 1;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// pipe_reg_chain_if
//   Producer/consumer handshake bundle for pipe_reg_chain.
//   Signals:
//     in_valid  producer -> chain   producer has data on in_data
//     in_data   producer -> chain   WIDTH-bit input data
//     in_ready  chain -> producer   chain accepts in_data this cycle
//     out_valid chain -> consumer   last stage holds valid data
//     out_data  chain -> consumer   last stage data
//     out_ready consumer -> chain   consumer accepts out_data this cycle
//   Modports: master = the environment around the chain, slave = the chain.
//
//   Handshake: a beat transfers on a rising clk edge where valid && ready are
//   both 1. Valid never depends combinationally on ready; ready may depend on
//   the downstream ready. While valid && !ready the sender holds data stable.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage
//   One register stage of pipe_reg_chain: a valid bit and a data register.
//   The stage loads from upstream whenever it is empty or downstream can take
//   its current contents (local ready). Data is only written when the incoming
//   beat is valid, so empty stages do not toggle.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     flush_i      clear the valid bit next cycle (data untouched)
//     up_valid_i   upstream valid
//     up_data_i    upstream data
//     dn_rdy_i     downstream ready
//     valid_o      stage valid (registered)
//     data_o       stage data (registered)
module pipe_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_rdy_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             ld;

  always_comb begin
    ld  = !v_q || dn_rdy_i;
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (ld) begin
      v_d = up_valid_i;
      if (up_valid_i) begin
        d_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   DEPTH-stage register pipeline for WIDTH-bit data with valid/ready flow
//   control, bubble collapse and synchronous flush. Unstalled latency is DEPTH
//   cycles at one item per cycle; a stalled chain fills to DEPTH items.
//   Ports:
//     clk, rst    clock, synchronous active-high reset (beats flush/handshakes)
//     flush       clear every stage valid bit next cycle; blocks input
//     bus         pipe_reg_chain_if.slave handshake bundle
//     occupancy   number of valid stages (only when PIPE_REG_CHAIN_OCC_EN
//                 is defined)
//   Build option: define PIPE_REG_CHAIN_OCC_EN to add the occupancy port.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  pipe_reg_chain_if.slave bus
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  if (DEPTH < MIN_DEPTH) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] stage_v;
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH:0]   rdy;

  // Ready ripples from the consumer back towards the input: a stage can take
  // a new beat if it is empty or if its own contents move on this cycle.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !stage_v[i] || rdy[i+1];
    end
  end

  assign up_v[0] = bus.in_valid;
  assign up_d[0] = bus.in_data;

  for (genvar i = 1; i < DEPTH; i++) begin : g_link
    assign up_v[i] = stage_v[i-1];
    assign up_d[i] = stage_d[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_reg_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush),
      .up_valid_i(up_v[i]),
      .up_data_i (up_d[i]),
      .dn_rdy_i  (rdy[i+1]),
      .valid_o   (stage_v[i]),
      .data_o    (stage_d[i])
    );
  end

  // Stage 0 also loads during flush/rst cycles, but those branches win inside
  // the stage, so masking in_ready here is what keeps the producer honest.
  assign bus.in_ready  = rdy[0] && !flush && !rst;
  assign bus.out_valid = stage_v[DEPTH-1];
  assign bus.out_data  = stage_d[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);
  logic [OCC_W-1:0] occ_cnt;

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + OCC_W'(stage_v[i]);
    end
  end

  assign occupancy = occ_cnt;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain
//   Directed and random bench for pipe_reg_chain. One 8-bit/3-deep instance
//   takes the directed sequences; 16-bit instances with DEPTH=1 and DEPTH=5
//   take random valid/ready traffic. Each instance has a queue model fed on
//   input transfers and drained on output transfers.
//   Honours PIPE_REG_CHAIN_OCC_EN the same way as the design.
module tb_pipe_reg_chain;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  pipe_reg_chain_if #(.WIDTH(8))  b3 ();
  pipe_reg_chain_if #(.WIDTH(16)) b1 ();
  pipe_reg_chain_if #(.WIDTH(16)) b5 ();

`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [1:0] occ3;
  logic [0:0] occ1;
  logic [2:0] occ5;
`endif

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b3)
`ifdef PIPE_REG_CHAIN_OCC_EN
    , .occupancy(occ3)
`endif
  );

  pipe_reg_chain #(.WIDTH(16), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(1'b0), .bus(b1)
`ifdef PIPE_REG_CHAIN_OCC_EN
    , .occupancy(occ1)
`endif
  );

  pipe_reg_chain #(.WIDTH(16), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .flush(1'b0), .bus(b5)
`ifdef PIPE_REG_CHAIN_OCC_EN
    , .occupancy(occ5)
`endif
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- scoreboards ----------------
  logic [7:0]  q3[$];
  logic [15:0] q1[$];
  logic [15:0] q5[$];
  int tx1 = 0, rx1 = 0, tx5 = 0, rx5 = 0;

  // Sampled mid-cycle: outputs and inputs are stable and describe what the
  // coming posedge will do. Order: output pop, then flush/rst drop, then push.
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef PIPE_REG_CHAIN_OCC_EN
      check("occ3_vs_model", 32'(occ3), 32'(q3.size()));
      check("occ5_vs_model", 32'(occ5), 32'(q5.size()));
      check("occ1_vs_model", 32'(occ1), 32'(q1.size()));
`endif
      if (b3.out_valid && b3.out_ready) begin
        if (q3.size() == 0) check("d3_unexpected_out", 32'(b3.out_data), 32'hDEAD);
        else check("d3_out_data", 32'(b3.out_data), 32'(q3.pop_front()));
      end
      if (rst || flush) q3.delete();
      if (b3.in_valid && b3.in_ready) q3.push_back(b3.in_data);

      if (b1.out_valid && b1.out_ready) begin
        rx1++;
        if (q1.size() == 0) check("d1_unexpected_out", 32'(b1.out_data), 32'hDEAD);
        else check("d1_out_data", 32'(b1.out_data), 32'(q1.pop_front()));
      end
      if (rst) q1.delete();
      if (b1.in_valid && b1.in_ready) begin
        tx1++;
        q1.push_back(b1.in_data);
      end

      if (b5.out_valid && b5.out_ready) begin
        rx5++;
        if (q5.size() == 0) check("d5_unexpected_out", 32'(b5.out_data), 32'hDEAD);
        else check("d5_out_data", 32'(b5.out_data), 32'(q5.pop_front()));
      end
      if (rst) q5.delete();
      if (b5.in_valid && b5.in_ready) begin
        tx5++;
        q5.push_back(b5.in_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int rdy_pct;

    rst          = 1'b1;
    flush        = 1'b0;
    b3.in_valid  = 1'b1;
    b3.in_data   = 8'hAA;
    b3.out_ready = 1'b1;
    b1.in_valid  = 1'b0;
    b1.in_data   = '0;
    b1.out_ready = 1'b1;
    b5.in_valid  = 1'b0;
    b5.in_data   = '0;
    b5.out_ready = 1'b1;

    // Reset: two cycles with a valid input pending.
    step();
    mon_en = 1'b1;
    step();
    check("rst_out_valid", 32'(b3.out_valid), 32'd0);
    check("rst_out_data", 32'(b3.out_data), 32'd0);
    check("rst_in_ready", 32'(b3.in_ready), 32'd0);
    check("rst_d5_out_valid", 32'(b5.out_valid), 32'd0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("rst_occ", 32'(occ3), 32'd0);
`endif
    rst         = 1'b0;
    b3.in_valid = 1'b0;
    settle();
    check("rst_release_in_ready", 32'(b3.in_ready), 32'd1);

    // Streaming: three back-to-back items, first out three cycles after accept.
    b3.in_valid = 1'b1;
    b3.in_data  = 8'h11;
    step();
    check("stream_lat1_valid", 32'(b3.out_valid), 32'd0);
    b3.in_data = 8'h22;
    step();
    check("stream_lat2_valid", 32'(b3.out_valid), 32'd0);
    b3.in_data = 8'h33;
    step();
    b3.in_valid = 1'b0;
    check("stream_first_valid", 32'(b3.out_valid), 32'd1);
    check("stream_first_data", 32'(b3.out_data), 32'h11);
    step();
    check("stream_second_data", 32'(b3.out_data), 32'h22);
    step();
    check("stream_third_data", 32'(b3.out_data), 32'h33);
    step();
    check("stream_empty_after", 32'(b3.out_valid), 32'd0);

    // Backpressure: five offers against a stalled consumer.
    b3.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      b3.in_valid = 1'b1;
      b3.in_data  = 8'h40 + 8'(acc);
      settle();
      if (b3.in_ready) acc++;
      step();
    end
    b3.in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd3);
    check("bp_in_ready_full", 32'(b3.in_ready), 32'd0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("bp_occ_full", 32'(occ3), 32'd3);
`endif
    b3.out_ready = 1'b1;
    settle();
    check("bp_in_ready_release", 32'(b3.in_ready), 32'd1);
    check("bp_head_data", 32'(b3.out_data), 32'h40);
    step();
    check("bp_second_data", 32'(b3.out_data), 32'h41);
    step();
    check("bp_third_data", 32'(b3.out_data), 32'h42);
    step();
    check("bp_drained", 32'(b3.out_valid), 32'd0);

    // Bubble collapse: A, gap, B against a stalled consumer.
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    b3.in_data   = 8'hA1;
    step();
    b3.in_valid = 1'b0;
    step();
    b3.in_valid = 1'b1;
    b3.in_data  = 8'hB2;
    settle();
    check("bubble_in_ready", 32'(b3.in_ready), 32'd1);
    step();
    b3.in_valid = 1'b0;
    step();
    step();
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("bubble_occ", 32'(occ3), 32'd2);
`endif
    check("bubble_hold_valid", 32'(b3.out_valid), 32'd1);
    check("bubble_hold_data", 32'(b3.out_data), 32'hA1);
    settle();
    check("bubble_in_ready_space", 32'(b3.in_ready), 32'd1);
    b3.out_ready = 1'b1;
    step();
    check("bubble_second", 32'(b3.out_data), 32'hB2);
    step();
    check("bubble_drained", 32'(b3.out_valid), 32'd0);

    // Flush: two items held, flush with a valid input offered.
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    b3.in_data   = 8'hC1;
    step();
    b3.in_data = 8'hC2;
    step();
    flush      = 1'b1;
    b3.in_data = 8'hEE;
    settle();
    check("flush_in_ready", 32'(b3.in_ready), 32'd0);
    step();
    flush       = 1'b0;
    b3.in_valid = 1'b0;
    check("flush_out_valid", 32'(b3.out_valid), 32'd0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("flush_occ", 32'(occ3), 32'd0);
`endif
    b3.out_ready = 1'b1;
    b3.in_valid  = 1'b1;
    b3.in_data   = 8'hD4;
    settle();
    check("post_flush_in_ready", 32'(b3.in_ready), 32'd1);
    step();
    b3.in_valid = 1'b0;
    check("post_flush_lat1", 32'(b3.out_valid), 32'd0);
    step();
    check("post_flush_lat2", 32'(b3.out_valid), 32'd0);
    step();
    check("post_flush_valid", 32'(b3.out_valid), 32'd1);
    check("post_flush_data", 32'(b3.out_data), 32'hD4);
    step();

    // Reset mid-stream: in-flight items vanish, data regs cleared.
    b3.out_ready = 1'b0;
    b3.in_valid  = 1'b1;
    b3.in_data   = 8'h5A;
    step();
    step();
    b3.in_valid = 1'b0;
    rst         = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 32'(b3.out_valid), 32'd0);
    check("midrst_out_data", 32'(b3.out_data), 32'd0);
    b3.out_ready = 1'b1;
    step();
    step();
    step();
    check("midrst_no_output", 32'(b3.out_valid), 32'd0);

    // Random traffic on the 16-bit DEPTH=1 and DEPTH=5 chains.
    for (int c = 0; c < 10000; c++) begin
      rdy_pct = (c < 5000) ? 70 : 35;
      b1.in_valid  = ($urandom_range(0, 99) < 60);
      b1.in_data   = 16'($urandom);
      b1.out_ready = ($urandom_range(0, 99) < rdy_pct);
      b5.in_valid  = ($urandom_range(0, 99) < 60);
      b5.in_data   = 16'($urandom);
      b5.out_ready = ($urandom_range(0, 99) < rdy_pct);
      step();
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    b5.in_valid  = 1'b0;
    b5.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();

    check("rand_d1_left", 32'(q1.size()), 32'd0);
    check("rand_d5_left", 32'(q5.size()), 32'd0);
    check("rand_d1_count", 32'(rx1), 32'(tx1));
    check("rand_d5_count", 32'(rx5), 32'(tx5));
    check("rand_d1_traffic", 32'(tx1 > 1000), 32'd1);
    check("rand_d5_traffic", 32'(tx5 > 1000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
